// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V front end.
// The fetch-fault predicate lives here so the IF stage and any later checker agree on one definition.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } if_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            fault;
    } if_id_t;

    // A wrapped pc (after 0xFFFF_FFFC + 4) lands below max_pc, but any pc past the end is caught here.
    function automatic logic fetch_fault(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] max_pc);
        return (pc[1:0] != 2'b00) || (pc > max_pc);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one if_id_t entry plus its valid bit.
// flush wins over load; with neither asserted the entry holds.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   flush_i,
    input  if_id_t entry_i,
    output logic   valid_o,
    output if_id_t entry_o
);

    logic   valid_q, valid_d;
    if_id_t entry_q, entry_d;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            entry_d = entry_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            entry_q.instr <= NOP_INSTR;
            entry_q.pc    <= '0;
            entry_q.fault <= 1'b0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

    assign valid_o = valid_q;
    assign entry_o = entry_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the pc, fetches from instructions_mem and hands words to decode over valid/ready.
// Redirects flush the in-flight entry; a faulting fetch parks the stage in HALT until redirected.
module instr_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault
);

    localparam logic [XLEN-1:0] MAX_PC = XLEN'(IMEM_BYTES - 4);

    if_state_t       state_q;
    logic [XLEN-1:0] pc_q;

    logic   fault;
    logic   take_redirect;
    logic   can_capture;
    logic   load;
    logic   flush;
    if_id_t entry_in;
    if_id_t entry_out;

    assign fault         = fetch_fault(pc_q, MAX_PC);
    assign take_redirect = redirect_valid && (state_q != BOOT);
    assign can_capture   = !id_valid || id_ready;

    assign load  = !take_redirect && (state_q == RUN) && can_capture;
    // In HALT the faulting entry is retired on acceptance without a replacement.
    assign flush = take_redirect || ((state_q == HALT) && id_valid && id_ready);

    assign entry_in.instr = fault ? NOP_INSTR : imem_instr;
    assign entry_in.pc    = pc_q;
    assign entry_in.fault = fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else if (take_redirect) begin
            state_q <= RUN;
            pc_q    <= redirect_pc;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (can_capture) begin
                        if (fault) begin
                            state_q <= HALT;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= BOOT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .flush_i (flush),
        .entry_i (entry_in),
        .valid_o (id_valid),
        .entry_o (entry_out)
    );

    assign imem_addr = pc_q;
    assign id_instr  = entry_out.instr;
    assign id_pc     = entry_out.pc;
    assign id_fault  = entry_out.fault;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus randomized ready/redirect traffic,
// with a scoreboard of the instruction stream decode should receive.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr, id_pc;
    logic        id_fault;

    logic [31:0] imem_addr2, imem_instr2;
    logic        id_valid2;
    logic [31:0] id_instr2, id_pc2;
    logic        id_fault2;

    logic [31:0] mem [1024];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign imem_instr  = mem[imem_addr[11:2]];
    assign imem_instr2 = mem[imem_addr2[11:2]];

    instr_fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(4096)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_fault(id_fault)
    );

    instr_fetch_stage #(.RESET_PC(32'd4092), .IMEM_BYTES(4096)) dut_top (
        .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
        .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2), .id_fault(id_fault2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Stream decode should see from pc onward: sequential words up to and including the first fault.
    function automatic void expect_from(input logic [31:0] start);
        logic [31:0] p;
        p = start;
        exp_q.delete();
        for (int i = 0; i < 1100; i++) begin
            exp_t e;
            e.pc    = p;
            e.fault = (p[1:0] != 2'b00) || (p > 32'd4092);
            e.instr = e.fault ? NOP : mem[p[11:2]];
            exp_q.push_back(e);
            if (e.fault) break;
            p = p + 32'd4;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every accepted handshake and checks stall stability.
    logic        prev_stall = 1'b0;
    logic [31:0] sv_pc, sv_instr, sv_addr;
    logic        sv_fault;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", id_valid, 1);
                chk("stall_pc", id_pc, sv_pc);
                chk("stall_instr", id_instr, sv_instr);
                chk("stall_fault", id_fault, sv_fault);
                chk("stall_addr", imem_addr, sv_addr);
            end
            if (id_valid && id_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_handshake: got id_pc=%h, no entry expected", id_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_pc", id_pc, e.pc);
                    chk("sb_instr", id_instr, e.instr);
                    chk("sb_fault", id_fault, e.fault);
                end
            end
            prev_stall = id_valid && !id_ready && !redirect_valid;
            sv_pc    = id_pc;
            sv_instr = id_instr;
            sv_fault = id_fault;
            sv_addr  = imem_addr;
        end
    end

    initial begin
        logic [31:0] t;
        logic [31:0] hold_pc, hold_instr, hold_addr;
        rst = 1'b1;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        expect_from(32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Boot cycle, then the first two words; the top-of-memory instance faults on its second fetch
        step();
        chk("boot_valid", id_valid, 0);
        chk("boot_valid_top", id_valid2, 0);
        step();
        chk("first_valid", id_valid, 1);
        chk("first_pc", id_pc, 32'h0);
        chk("first_instr", id_instr, 32'h0050_0093);
        chk("top_first_pc", id_pc2, 32'd4092);
        chk("top_first_fault", id_fault2, 0);
        chk("top_first_instr", id_instr2, mem[1023]);
        step();
        chk("second_pc", id_pc, 32'h4);
        chk("second_instr", id_instr, 32'h0010_0113);
        chk("top_second_pc", id_pc2, 32'd4096);
        chk("top_second_fault", id_fault2, 1);
        chk("top_second_instr", id_instr2, NOP);
        step();
        chk("top_halt_valid", id_valid2, 0);
        chk("top_halt_addr", imem_addr2, 32'd4096);

        // Three-cycle stall mid-stream
        step();
        id_ready = 1'b0;
        hold_pc = id_pc; hold_instr = id_instr; hold_addr = imem_addr;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dstall_pc", id_pc, hold_pc);
            chk("dstall_instr", id_instr, hold_instr);
            chk("dstall_addr", imem_addr, hold_addr);
        end
        id_ready = 1'b1;
        repeat (3) step();

        // Redirect while stalled with a live entry
        id_ready = 1'b0;
        step();
        chk("pre_redirect_valid", id_valid, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h40; expect_from(32'h40);
        step();
        redirect_valid = 1'b0;
        chk("redir_flush_valid", id_valid, 0);
        chk("redir_addr", imem_addr, 32'h40);
        id_ready = 1'b1;
        step();
        chk("redir_target_valid", id_valid, 1);
        chk("redir_target_pc", id_pc, 32'h40);
        repeat (2) step();

        // Misaligned redirect: one faulting entry, then silence until redirected
        redirect_valid = 1'b1; redirect_pc = 32'h42; expect_from(32'h42);
        step();
        redirect_valid = 1'b0;
        step();
        chk("mis_fault", id_fault, 1);
        chk("mis_instr", id_instr, NOP);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mis_halt_valid", id_valid, 0);
            chk("mis_halt_addr", imem_addr, 32'h42);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0; expect_from(32'h0);
        step();
        redirect_valid = 1'b0;
        repeat (4) step();

        // Redirect to the last word of the address space: fault, pc must not wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; expect_from(32'hFFFF_FFFC);
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_fault", id_fault, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrap_pc_hold", imem_addr, 32'hFFFF_FFFC);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0; expect_from(32'h0);
        step();
        redirect_valid = 1'b0;
        repeat (3) step();

        // Asynchronous reset between edges, with a redirect during BOOT that must be ignored
        @(posedge clk);
        #3 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_valid", id_valid, 0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid_top", id_valid2, 0);
        @(posedge clk);
        #2;
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        rst = 1'b0;
        expect_from(32'h0);
        step();
        chk("reboot_valid", id_valid, 0);
        redirect_valid = 1'b0;
        step();
        chk("reboot_first_valid", id_valid, 1);
        chk("reboot_first_pc", id_pc, 32'h0);

        // Randomized ready and redirect traffic
        for (int n = 0; n < 3000; n++) begin
            redirect_valid = 1'b0;
            id_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 4) begin
                case ($urandom_range(0, 9))
                    7:       t = 32'($urandom_range(0, 4095)) | 32'h1;
                    8:       t = ($urandom_range(0, 1) != 0) ? 32'd4092 : 32'd4096;
                    9:       t = 32'hFFFF_FFFC;
                    default: t = 32'($urandom_range(0, 1023)) << 2;
                endcase
                redirect_valid = 1'b1;
                redirect_pc = t;
                expect_from(t);
            end
            step();
        end
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
